// File: rtl/cmd_parse.sv
// Command RAM reader: fetches a 10-byte frame through ram_cmd port B, checks the
// header and checksum, and publishes the frame type and payload on a fs/fd handshake.
module cmd_parse #(
    parameter logic [7:0]  BASE_ADDR = 8'h00,
    parameter logic [7:0]  HEAD0     = 8'h55,
    parameter logic [7:0]  HEAD1     = 8'hAA,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fs,
    output logic        fd,
    output logic [7:0]  ram_cmd_rxa,
    input  logic [7:0]  ram_cmd_rxd,
    output logic [3:0]  com_btype,
    output logic [51:0] cache_cmd,
    output logic [1:0]  err_code,
    output logic [7:0]  cmd_cnt
);

    localparam int unsigned KW    = 4;
    localparam int unsigned PAYW  = 56;
    localparam int unsigned CMDW  = 52;
    localparam logic [KW-1:0] LAST_K = KW'(9);
    localparam logic [KW-1:0] DONE_K = KW'(10);

    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_READ  = 4'b0010;
    localparam logic [3:0] S_CHECK = 4'b0100;
    localparam logic [3:0] S_DONE  = 4'b1000;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_HEAD = 2'd1;
    localparam logic [1:0] ERR_SUM  = 2'd2;

    logic [3:0]        state_q,  state_d;
    logic [7:0]        rxa_q,    rxa_d;
    logic [KW-1:0]     rd_k_q,   rd_k_d;
    logic [KW-1:0]     cap_k_q,  cap_k_d;
    logic [RD_LAT-1:0] vld_q,    vld_d;
    logic [7:0]        hdr0_q,   hdr0_d;
    logic [7:0]        hdr1_q,   hdr1_d;
    logic [PAYW-1:0]   pay_q,    pay_d;
    logic [7:0]        sum_q,    sum_d;
    logic [7:0]        chk_q,    chk_d;
    logic [3:0]        btype_q,  btype_d;
    logic [CMDW-1:0]   cmd_q,    cmd_d;
    logic [1:0]        err_q,    err_d;
    logic [7:0]        cnt_q,    cnt_d;
    logic              issue;

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        rxa_d   = rxa_q;
        rd_k_d  = rd_k_q;
        cap_k_d = cap_k_q;
        vld_d   = '0;
        hdr0_d  = hdr0_q;
        hdr1_d  = hdr1_q;
        pay_d   = pay_q;
        sum_d   = sum_q;
        chk_d   = chk_q;
        btype_d = btype_q;
        cmd_d   = cmd_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Every IDLE cycle wipes frame state so a restart never sees stale bytes
                rxa_d   = BASE_ADDR;
                rd_k_d  = '0;
                cap_k_d = '0;
                hdr0_d  = '0;
                hdr1_d  = '0;
                pay_d   = '0;
                sum_d   = '0;
                chk_d   = '0;
                if (fs) state_d = S_READ;
            end
            S_READ: begin
                if (!fs) begin
                    state_d = S_IDLE;
                    rxa_d   = BASE_ADDR;
                end else begin
                    issue = (rd_k_q <= LAST_K);
                    vld_d = RD_LAT'({vld_q, issue});
                    if (issue) begin
                        if (rd_k_q == LAST_K) begin
                            rd_k_d = DONE_K;
                        end else begin
                            rd_k_d = KW'(rd_k_q + KW'(1));
                            rxa_d  = 8'(rxa_q + 8'd1);
                        end
                    end
                    if (vld_q[RD_LAT-1]) begin
                        cap_k_d = KW'(cap_k_q + KW'(1));
                        case (cap_k_q)
                            KW'(0):  hdr0_d = ram_cmd_rxd;
                            KW'(1):  hdr1_d = ram_cmd_rxd;
                            LAST_K: begin
                                chk_d   = ram_cmd_rxd;
                                state_d = S_CHECK;
                            end
                            default: begin
                                pay_d = {pay_q[PAYW-9:0], ram_cmd_rxd};
                                sum_d = 8'(sum_q + ram_cmd_rxd);
                            end
                        endcase
                    end
                end
            end
            S_CHECK: begin
                if (!fs) begin
                    state_d = S_IDLE;
                    rxa_d   = BASE_ADDR;
                end else begin
                    state_d = S_DONE;
                    if ((hdr0_q != HEAD0) || (hdr1_q != HEAD1)) begin
                        err_d = ERR_HEAD;
                    end else if (sum_q != chk_q) begin
                        err_d = ERR_SUM;
                    end else begin
                        err_d   = ERR_OK;
                        btype_d = pay_q[PAYW-1:CMDW];
                        cmd_d   = pay_q[CMDW-1:0];
                        cnt_d   = 8'(cnt_q + 8'd1);
                    end
                end
            end
            S_DONE: begin
                if (!fs) begin
                    state_d = S_IDLE;
                    rxa_d   = BASE_ADDR;
                end
            end
            default: begin
                state_d = S_IDLE;
                rxa_d   = BASE_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rxa_q   <= BASE_ADDR;
            rd_k_q  <= '0;
            cap_k_q <= '0;
            vld_q   <= '0;
            hdr0_q  <= '0;
            hdr1_q  <= '0;
            pay_q   <= '0;
            sum_q   <= '0;
            chk_q   <= '0;
            btype_q <= '0;
            cmd_q   <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rxa_q   <= rxa_d;
            rd_k_q  <= rd_k_d;
            cap_k_q <= cap_k_d;
            vld_q   <= vld_d;
            hdr0_q  <= hdr0_d;
            hdr1_q  <= hdr1_d;
            pay_q   <= pay_d;
            sum_q   <= sum_d;
            chk_q   <= chk_d;
            btype_q <= btype_d;
            cmd_q   <= cmd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fd          = state_q[3];
    assign ram_cmd_rxa = rxa_q;
    assign com_btype   = btype_q;
    assign cache_cmd   = cmd_q;
    assign err_code    = err_q;
    assign cmd_cnt     = cnt_q;

endmodule
